// File: rtl/bus_write_sequencer.sv
// bus_write_sequencer: queues write commands in a small FIFO and replays each
// one onto a shared data bus as a SETUP cycle (bus stable, no enables)
// followed by a WRITE cycle (selected register enable(s) high).
module bus_write_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_dst,
  input  logic        cmd_bcast,
  input  logic [15:0] cmd_data,
  output logic [15:0] data_bus,
  output logic        A_en,
  output logic        B_en,
  output logic        C_en,
  output logic        D_en,
  output logic        busy,
  output logic [4:0]  fifo_count
);

  localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [18:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [4:0]        r_count;
  logic [18:0]       r_hold;
  logic [3:0]        r_en;
  logic              w_push;
  logic              w_pop;
  logic              w_ready;
  logic [3:0]        w_enNext;

  // Ready only looks at occupancy, so a full FIFO refuses even when a pop
  // happens on the same edge; it also keeps tracking the count during reset.
  assign w_ready    = (r_count < DEPTH_CNT);
  assign w_push     = cmd_valid && w_ready;
  assign cmd_ready  = w_ready;
  assign fifo_count = r_count;
  assign busy       = (r_state != IDLE) || (r_count != 5'd0);
  assign data_bus   = r_hold[15:0];
  assign A_en       = r_en[0];
  assign B_en       = r_en[1];
  assign C_en       = r_en[2];
  assign D_en       = r_en[3];

  // Storage array for queued commands {bcast, dst, data}; entries need no reset.
  always_ff @(posedge Clock) begin
    if (Reset && w_push) begin
      r_mem[r_wrPtr] <= {cmd_bcast, cmd_dst, cmd_data};
    end
  end

  // State register plus FIFO pointers, occupancy, hold register and enables.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= 5'd0;
      r_hold  <= 19'd0;
      r_en    <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_en    <= w_enNext;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
        r_hold  <= r_mem[r_rdPtr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 5'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 5'd1;
      end
    end
  end

  // Next-state logic: a transfer is always SETUP then WRITE; leave WRITE or
  // IDLE straight into SETUP whenever another command is waiting.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_nextState = (r_count != 5'd0) ? SETUP : IDLE;
      SETUP:   w_nextState = WRITE;
      WRITE:   w_nextState = (r_count != 5'd0) ? SETUP : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode: pop in IDLE/WRITE when non-empty, and compute the enable
  // pattern that becomes visible during the WRITE cycle after SETUP.
  always_comb begin
    w_pop    = 1'b0;
    w_enNext = 4'd0;
    case (r_state)
      IDLE:  w_pop = (r_count != 5'd0);
      WRITE: w_pop = (r_count != 5'd0);
      SETUP: w_enNext = r_hold[18] ? 4'hF : (4'b0001 << r_hold[17:16]);
      default: begin
        w_pop    = 1'b0;
        w_enNext = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_write_sequencer.sv
// Testbench for bus_write_sequencer: a transaction-level model decides when
// commands are accepted and popped; a monitor checks the DUT each cycle
// against that model and a scoreboard of expected enable pulses.
module tb_bus_write_sequencer;

  localparam int DEPTH = 4;

  logic        Clock;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dst;
  logic        cmd_bcast;
  logic [15:0] cmd_data;
  logic [15:0] data_bus;
  logic        A_en, B_en, C_en, D_en;
  logic        busy;
  logic [4:0]  fifo_count;

  typedef struct {
    logic        bcast;
    logic [1:0]  dst;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    logic [3:0]  en;
    logic [15:0] data;
    int          edgeNo;
  } exp_t;

  cmd_t        mq[$];
  exp_t        sbQ[$];
  int          edgeCount     = 0;
  int          lastPop       = -100;
  logic [15:0] modelBus      = 16'h0000;
  logic        modelAccepted = 1'b0;
  logic        checking      = 1'b0;
  int          checkCount    = 0;
  int          failCount     = 0;

  bus_write_sequencer #(.DEPTH(DEPTH)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dst    (cmd_dst),
    .cmd_bcast  (cmd_bcast),
    .cmd_data   (cmd_data),
    .data_bus   (data_bus),
    .A_en       (A_en),
    .B_en       (B_en),
    .C_en       (C_en),
    .D_en       (D_en),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Free-running clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeCount);
    end
  endtask

  // Reference model: the FIFO accepts while fewer than DEPTH commands wait,
  // and the sequencer takes the oldest command whenever it is free, which is
  // at most once every two edges. Each taken command pulses its enable(s)
  // during the cycle after the following edge.
  always @(posedge Clock) begin
    cmd_t c;
    exp_t e;
    logic readyNow;
    edgeCount++;
    modelAccepted = 1'b0;
    if (!Reset) begin
      mq.delete();
      sbQ.delete();
      modelBus = 16'h0000;
      lastPop  = -100;
      checking = 1'b1;
    end else begin
      readyNow = (mq.size() < DEPTH);
      if (mq.size() != 0 && (edgeCount - lastPop) >= 2) begin
        c        = mq.pop_front();
        lastPop  = edgeCount;
        modelBus = c.data;
        e.en     = c.bcast ? 4'hF : (4'b0001 << c.dst);
        e.data   = c.data;
        e.edgeNo = edgeCount + 1;
        sbQ.push_back(e);
      end
      if (cmd_valid && readyNow) begin
        c.bcast = cmd_bcast;
        c.dst   = cmd_dst;
        c.data  = cmd_data;
        mq.push_back(c);
        modelAccepted = 1'b1;
      end
    end
  end

  // Monitor: compares status outputs with the model every cycle and pops the
  // scoreboard whenever an enable pulse is due.
  always @(negedge Clock) begin
    logic [3:0] w;
    if (checking) begin
      w = {D_en, C_en, B_en, A_en};
      checkOutput("fifo_count", 32'(fifo_count), 32'(mq.size()));
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      checkOutput("busy", 32'(busy), 32'((mq.size() != 0) || ((edgeCount - lastPop) <= 1)));
      checkOutput("data_bus", 32'(data_bus), 32'(modelBus));
      if (sbQ.size() != 0 && sbQ[0].edgeNo == edgeCount) begin
        checkOutput("pulse enables", 32'(w), 32'(sbQ[0].en));
        checkOutput("pulse data_bus", 32'(data_bus), 32'(sbQ[0].data));
        void'(sbQ.pop_front());
      end else begin
        checkOutput("quiet enables", 32'(w), 32'd0);
      end
    end
  end

  // Offer one command until accepted (bounded), then idle for gap cycles.
  task automatic applyStimulus(input logic b, input logic [1:0] d, input logic [15:0] dat, input int gap);
    int tries;
    tries     = 0;
    cmd_bcast = b;
    cmd_dst   = d;
    cmd_data  = dat;
    cmd_valid = 1'b1;
    do begin
      @(negedge Clock);
      tries++;
    end while (!modelAccepted && tries < 60);
    checkOutput("accept timeout", 32'(modelAccepted), 32'd1);
    cmd_valid = 1'b0;
    repeat (gap) @(negedge Clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || sbQ.size() != 0) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    repeat (3) @(negedge Clock);
    checkOutput("drain queue", 32'(mq.size()), 32'd0);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    Reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_bcast = 1'b0;
    cmd_dst   = 2'd0;
    cmd_data  = 16'h0000;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    $display("[TB] single write");
    applyStimulus(1'b0, 2'd2, 16'h00A5, 0);
    drain();

    $display("[TB] burst order");
    applyStimulus(1'b0, 2'd0, 16'h1111, 0);
    applyStimulus(1'b0, 2'd1, 16'h2222, 0);
    applyStimulus(1'b0, 2'd2, 16'h3333, 0);
    applyStimulus(1'b0, 2'd3, 16'h4444, 0);
    drain();

    $display("[TB] backpressure");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'(i), 16'(16'h5000 + i), 0);
    end
    drain();

    $display("[TB] broadcast");
    applyStimulus(1'b1, 2'd1, 16'hBEEF, 0);
    drain();

    $display("[TB] wrap-around");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 4));
    end
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 16'($urandom),
                    $urandom_range(0, 3));
    end
    drain();

    $display("[TB] reset mid-transfer");
    applyStimulus(1'b0, 2'd0, 16'h1001, 0);
    applyStimulus(1'b0, 2'd1, 16'h1002, 0);
    applyStimulus(1'b0, 2'd2, 16'h1003, 0);
    Reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 16'hDEAD;
    repeat (2) @(negedge Clock);
    Reset     = 1'b1;
    cmd_valid = 1'b0;
    repeat (12) @(negedge Clock);

    checkOutput("final scoreboard", 32'(sbQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/bus_write_sequencer.md
BUS_WRITE_SEQUENCER -- requirements
Module: bus_write_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the command FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port Clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous active-low reset, sampled on rising Clock.
REQ-004 SHALL have port cmd_valid  input  1  upstream offers a write command.
REQ-005 SHALL have port cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-006 SHALL have port cmd_dst  input  2  destination register select: 0=A, 1=B, 2=C, 3=D.
REQ-007 SHALL have port cmd_bcast  input  1  write cmd_data to all four registers; overrides cmd_dst.
REQ-008 SHALL have port cmd_data  input  16  value to place on the data bus.
REQ-009 SHALL have port data_bus  output  16  shared bus value presented to register file.
REQ-010 SHALL have ports A_en, B_en, C_en, D_en  output  1 each  per-register load enables.
REQ-011 SHALL have port busy  output  1  FIFO non-empty or transfer in progress.
REQ-012 SHALL have port fifo_count  output  5  number of commands queued and not yet popped.

Function
REQ-013 SHALL accept a command (push {cmd_bcast, cmd_dst, cmd_data}) at a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-014 SHALL drive cmd_ready = 1 exactly when fifo_count < DEPTH; a push is refused when full even if a pop occurs the same edge.
REQ-015 SHALL update fifo_count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-016 SHALL implement FSM states IDLE, SETUP, WRITE; all outputs except cmd_ready and busy are registered.
REQ-017 IDLE: if fifo_count != 0, pop head into hold register, load data_bus with its data, go SETUP; else stay IDLE.
REQ-018 SETUP: all enables 0, data_bus stable at held data; unconditionally go WRITE.
REQ-019 WRITE: for one cycle assert the selected enable only (all four if bcast), data_bus unchanged.
REQ-020 WRITE exit: if fifo_count != 0 pop next command into hold register, load data_bus, go SETUP; else go IDLE.
REQ-021 SHALL keep enables mutually one-hot or all-zero except in bcast WRITE, never asserted in IDLE or SETUP.
REQ-022 SHALL hold data_bus at its last driven value while IDLE.
REQ-023 Latency: command pushed at edge N -> data_bus valid after edge N+1, enable high between edges N+2 and N+3, register loads at edge N+3.
REQ-024 Throughput: back-to-back queued commands SHALL produce one enable pulse every 2 cycles, in FIFO order, with no gap cycle.
REQ-025 SHALL drive busy = (state != IDLE) or (fifo_count != 0).
REQ-026 FIFO read/write pointers SHALL wrap modulo DEPTH with no loss or duplication of entries.

Reset
REQ-027 When Reset=0 at a rising edge, SHALL set state IDLE, fifo_count 0, pointers 0, data_bus 16'h0000, all enables 0, hold register 0.
REQ-028 During reset cmd_ready SHALL still reflect fifo_count (1 after first reset edge); commands presented while Reset=0 SHALL be discarded.
REQ-029 Reset asserted during SETUP or WRITE SHALL abort the transfer: enables 0 after that edge, queued commands flushed, no further enable pulses.

Verification
REQ-030 Single write: push dst=2, data=16'h00A5 at edge 1 -> data_bus=00A5 after edge 2, C_en=1 only between edges 3 and 4, busy low after edge 4.
REQ-031 Burst order: push dst 0,1,2,3 data 1111,2222,3333,4444 on consecutive edges -> A_en,B_en,C_en,D_en pulses every 2 cycles with matching data_bus, never two enables high together.
REQ-032 Full/backpressure: hold cmd_valid=1 with 6 commands, DEPTH=4 -> cmd_ready drops when fifo_count=4, refused command retried later, all 6 emerge in order, none lost or duplicated.
REQ-033 Broadcast: push bcast=1, dst=1, data=16'hBEEF -> A_en..D_en all high for exactly one cycle with data_bus=BEEF.
REQ-034 Reset mid-transfer: queue 3 commands, drive Reset=0 during first WRITE -> after that edge enables 0, data_bus 0000, fifo_count 0, busy 0; no pulses after Reset returns 1.
REQ-035 Wrap-around: push/pop 10 commands with varied gaps at DEPTH=4 -> output order and data match input exactly across pointer wrap.
